// File: rtl/weight_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : weight_stream_reader_pkg
//  Brief    : Shared defaults, FSM encodings and helpers for the weight reader.
//  Revision : 1.0
// ============================================================================
package weight_stream_reader_pkg;

    localparam int c_DEF_DATA_W     = 16;
    localparam int c_DEF_ADDR_W     = 5;
    localparam int c_DEF_DEPTH      = 28;
    localparam int c_DEF_FIFO_DEPTH = 2;

    typedef logic [1:0] state_t;

    localparam state_t c_S_IDLE  = 2'd0;
    localparam state_t c_S_FETCH = 2'd1;
    localparam state_t c_S_DRAIN = 2'd2;
    localparam state_t c_S_DONE  = 2'd3;

    // A pointer into a one-entry buffer still needs one bit to exist.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : weight_stream_reader_pkg
`default_nettype wire

// File: rtl/weight_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : weight_sync_fifo
//  Brief    : Small first-word-fall-through synchronous FIFO with occupancy count.
//  Revision : 1.0
// ============================================================================
module weight_sync_fifo
    import weight_stream_reader_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = ptr_width(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_empty    = w_empty;

endmodule : weight_sync_fifo
`default_nettype wire

// File: rtl/weight_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : weight_stream_reader
//  Brief    : Sweeps one weight BRAM and streams its words to a MAC via valid/ready.
//  Revision : 1.0
// ============================================================================
module weight_stream_reader
    import weight_stream_reader_pkg::*;
#(
    parameter int DATA_W     = c_DEF_DATA_W,
    parameter int ADDR_W     = c_DEF_ADDR_W,
    parameter int DEPTH      = c_DEF_DEPTH,
    parameter int FIFO_DEPTH = c_DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    output logic              bram_we,
    output logic [DATA_W-1:0] bram_di,
    input  logic [DATA_W-1:0] bram_do,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_OCC_W = c_CNT_W + 1;
    localparam logic [ADDR_W:0]   c_DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W:0]   r_rd_cnt;
    logic [ADDR_W-1:0] r_bram_addr;
    logic              r_bram_en;
    logic              r_pending;
    logic              r_busy;
    logic              r_done;

    logic [DATA_W:0]   w_head;
    logic [c_CNT_W-1:0] w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_pop;
    logic              w_more;
    logic              w_room;
    logic              w_issue;
    logic              w_issue_last;
    logic [c_OCC_W-1:0] w_occ;
    logic [c_OCC_W-1:0] w_limit;

    assign w_pop        = !w_fifo_empty && out_ready;
    assign w_more       = (r_rd_cnt < c_DEPTH_CNT);
    assign w_issue_last = (r_rd_cnt == c_LAST_CNT);

    // Occupancy counts the word still on its way from the BRAM, so a full
    // buffer stalls issue before any read could be lost.
    assign w_occ   = c_OCC_W'(w_fifo_count) + c_OCC_W'(r_pending);
    assign w_limit = c_OCC_W'(FIFO_DEPTH) + c_OCC_W'(w_pop);
    assign w_room  = w_fifo_full ? (w_pop && !r_pending) : (w_occ < w_limit);

    always_comb begin
        w_issue = 1'b0;
        case (r_state)
            c_S_IDLE:  w_issue = start;
            c_S_FETCH: w_issue = w_more && w_room;
            default:   w_issue = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_rd_cnt    <= '0;
            r_bram_addr <= '0;
            r_bram_en   <= 1'b0;
            r_pending   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_bram_en <= w_issue;
            r_pending <= w_issue;
            r_done    <= 1'b0;
            if (w_issue) begin
                r_bram_addr <= r_rd_cnt[ADDR_W-1:0];
                r_rd_cnt    <= r_rd_cnt + 1'b1;
            end
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_state <= w_issue_last ? c_S_DRAIN : c_S_FETCH;
                    end
                end
                c_S_FETCH: begin
                    if (w_issue && w_issue_last) begin
                        r_state <= c_S_DRAIN;
                    end
                end
                c_S_DRAIN: begin
                    if (w_pop && w_head[DATA_W]) begin
                        r_state <= c_S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                c_S_DONE: begin
                    r_state  <= c_S_IDLE;
                    r_rd_cnt <= '0;
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    weight_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (c_CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_pending),
        .i_push_data ({(r_bram_addr == c_LAST_ADDR), bram_do}),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign bram_addr = r_bram_addr;
    assign bram_en   = r_bram_en;
    assign bram_we   = 1'b0;
    assign bram_di   = '0;
    assign out_valid = !w_fifo_empty;
    assign out_data  = w_fifo_empty ? '0 : w_head[DATA_W-1:0];
    assign out_last  = !w_fifo_empty && w_head[DATA_W];
    assign busy      = r_busy;
    assign done      = r_done;

endmodule : weight_stream_reader
`default_nettype wire

// File: tb/tb_weight_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_weight_stream_reader
//  Brief    : Directed self-checking bench with a negedge-read BRAM model.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_weight_stream_reader;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 5;
    localparam int DEPTH      = 28;
    localparam int FIFO_DEPTH = 2;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              start     = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] bram_do   = '0;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_en;
    logic              bram_we;
    logic [DATA_W-1:0] bram_di;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_fail = 0;

    weight_stream_reader #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_di   (bram_di),
        .bram_do   (bram_do),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [DEPTH];
    initial begin
        for (int k = 0; k < DEPTH; k++) mem[k] = 16'h0100 + 16'(k);
    end

    always @(negedge clk) begin
        if (bram_en) bram_do <= mem[bram_addr];
    end

    // Passive monitor: records transfers and stream-protocol observations.
    int             issued, xfers, max_out, stall_viol, done_cnt;
    bit             we_seen = 1'b0;
    logic [16:0]    got [$];
    logic           prev_stall = 1'b0;
    logic [16:0]    prev_word = '0;

    always @(posedge clk) begin
        if (bram_we !== 1'b0) we_seen = 1'b1;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (out_valid !== 1'b1 || {out_last, out_data} !== prev_word))
                stall_viol++;
            if (bram_en) issued++;
            if (out_valid && out_ready) begin
                got.push_back({out_last, out_data});
                xfers++;
            end
            if (issued - xfers > max_out) max_out = issued - xfers;
            if (done) done_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
        end
    end

    task automatic clear_mon();
        issued = 0; xfers = 0; max_out = 0; stall_viol = 0; done_cnt = 0;
        got.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [24:0] act;
        rst = 1'b1;
        repeat (3) tick();
        act = {bram_addr, bram_en, bram_di, out_valid, out_last, busy, done};
        n_cmp++;
        if (act !== '0) begin
            n_fail++; $display("FAIL reset_ctrl: got %h, expected 0", act);
        end
        n_cmp++;
        if (out_data !== 16'h0000) begin
            n_fail++; $display("FAIL reset_data: got %h, expected 0000", out_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_rate();
        logic [25:0] act, exp;
        logic        e_en, e_valid;
        logic [4:0]  e_addr;
        logic [15:0] e_data;
        out_ready = 1'b1;
        clear_mon();
        pulse_start();
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) tick();
            e_en    = (k <= 27);
            e_addr  = (k <= 27) ? 5'(k) : 5'd27;
            e_valid = (k >= 1) && (k <= 28);
            e_data  = e_valid ? 16'h0100 + 16'(k - 1) : 16'h0000;
            exp = {e_en, e_addr, e_valid, e_data, (k == 28), (k <= 28), (k == 29)};
            act = {bram_en, bram_addr, out_valid, out_data, out_last, busy, done};
            n_cmp++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL full_rate cycle %0d: got %h, expected %h", k, act, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [16:0] exp;
        clear_mon();
        out_ready = 1'b0;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
        out_ready = 1'b1;
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL bp_done: got no done, expected done pulse"); end
        n_cmp++;
        if (got.size() != DEPTH) begin
            n_fail++; $display("FAIL bp_count: got %0d, expected %0d", got.size(), DEPTH);
        end
        for (int k = 0; k < got.size() && k < DEPTH; k++) begin
            exp = {(k == DEPTH - 1), 16'h0100 + 16'(k)};
            n_cmp++;
            if (got[k] !== exp) begin
                n_fail++; $display("FAIL bp_word %0d: got %h, expected %h", k, got[k], exp);
            end
        end
        n_cmp++;
        if (stall_viol != 0) begin
            n_fail++; $display("FAIL bp_stable: got %0d unstable stalls, expected 0", stall_viol);
        end
        n_cmp++;
        if (max_out > FIFO_DEPTH) begin
            n_fail++; $display("FAIL bp_outstanding: got %0d, expected <= %0d", max_out, FIFO_DEPTH);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_stall();
        bit ok;
        logic [16:0] exp;
        clear_mon();
        out_ready = 1'b0;
        pulse_start();
        repeat (10) tick();
        n_cmp++;
        if (issued != 2) begin n_fail++; $display("FAIL stall_reads: got %0d, expected 2", issued); end
        n_cmp++;
        if ({bram_en, out_valid, out_data} !== {1'b0, 1'b1, 16'h0100}) begin
            n_fail++;
            $display("FAIL stall_head: got en=%b valid=%b data=%h, expected en=0 valid=1 data=0100",
                     bram_en, out_valid, out_data);
        end
        out_ready = 1'b1;
        wait_done(100, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL stall_done: got no done, expected done pulse"); end
        n_cmp++;
        if (got.size() != DEPTH) begin
            n_fail++; $display("FAIL stall_count: got %0d, expected %0d", got.size(), DEPTH);
        end
        for (int k = 0; k < got.size() && k < DEPTH; k++) begin
            exp = {(k == DEPTH - 1), 16'h0100 + 16'(k)};
            n_cmp++;
            if (got[k] !== exp) begin
                n_fail++; $display("FAIL stall_word %0d: got %h, expected %h", k, got[k], exp);
            end
        end
        tick();
    endtask

    task automatic test_start_during_busy();
        bit ok;
        logic [16:0] exp;
        clear_mon();
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 50 && got.size() < 5; i++) tick();
        pulse_start();
        wait_done(100, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL busy_done: got no done, expected done pulse"); end
        // START presented so that it is sampled in the DONE state.
        pulse_start();
        repeat (4) tick();
        n_cmp++;
        if ({busy, bram_en} !== 2'b00) begin
            n_fail++; $display("FAIL done_start: got busy=%b en=%b, expected 0 0", busy, bram_en);
        end
        n_cmp++;
        if (issued != DEPTH || done_cnt != 1) begin
            n_fail++;
            $display("FAIL busy_reads: got reads=%0d dones=%0d, expected %0d 1", issued, done_cnt, DEPTH);
        end
        n_cmp++;
        if (got.size() != DEPTH) begin
            n_fail++; $display("FAIL busy_count: got %0d, expected %0d", got.size(), DEPTH);
        end
        for (int k = 0; k < got.size() && k < DEPTH; k++) begin
            exp = {(k == DEPTH - 1), 16'h0100 + 16'(k)};
            n_cmp++;
            if (got[k] !== exp) begin
                n_fail++; $display("FAIL busy_word %0d: got %h, expected %h", k, got[k], exp);
            end
        end
    endtask

    task automatic test_restart();
        bit ok;
        clear_mon();
        out_ready = 1'b1;
        pulse_start();
        n_cmp++;
        if ({bram_en, bram_addr, busy} !== {1'b1, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL restart_addr: got en=%b addr=%0d busy=%b, expected 1 0 1", bram_en, bram_addr, busy);
        end
        wait_done(100, ok);
        n_cmp++;
        if (!ok || got.size() != DEPTH || got[0] !== 17'h00100 || got[DEPTH-1] !== 17'h1011B) begin
            n_fail++;
            $display("FAIL restart_seq: got ok=%b n=%0d, expected ok=1 n=%0d with 0100..011B", ok, got.size(), DEPTH);
        end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        bit ok;
        int seen;
        logic [16:0] exp;
        clear_mon();
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 50 && got.size() < 9; i++) tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({bram_addr, bram_en, out_valid, out_data, out_last, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got addr=%0d en=%b valid=%b data=%h last=%b busy=%b done=%b, expected all 0",
                     bram_addr, bram_en, out_valid, out_data, out_last, busy, done);
        end
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            tick();
            if (out_valid || bram_en) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_fail++; $display("FAIL midrst_stale: got %0d active cycles, expected 0", seen); end
        n_cmp++;
        if (got.size() != 9) begin n_fail++; $display("FAIL midrst_xfers: got %0d, expected 9", got.size()); end
        clear_mon();
        pulse_start();
        wait_done(100, ok);
        n_cmp++;
        if (!ok || got.size() != DEPTH) begin
            n_fail++; $display("FAIL midrst_sweep: got ok=%b n=%0d, expected ok=1 n=%0d", ok, got.size(), DEPTH);
        end
        for (int k = 0; k < got.size() && k < DEPTH; k++) begin
            exp = {(k == DEPTH - 1), 16'h0100 + 16'(k)};
            n_cmp++;
            if (got[k] !== exp) begin
                n_fail++; $display("FAIL midrst_word %0d: got %h, expected %h", k, got[k], exp);
            end
        end
        tick();
    endtask

    task automatic test_write_port();
        n_cmp++;
        if (we_seen !== 1'b0) begin n_fail++; $display("FAIL bram_we: got high at some edge, expected always 0"); end
        n_cmp++;
        if (bram_di !== 16'h0000) begin n_fail++; $display("FAIL bram_di: got %h, expected 0000", bram_di); end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_backpressure();
        test_stall();
        test_start_during_busy();
        test_restart();
        test_reset_mid_sweep();
        test_write_port();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_weight_stream_reader
`default_nettype wire
